// File: rtl/sram_arb_pkg.sv
// Shared constants, types and arbitration helpers for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int NUM_PORTS       = 2;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF  = 12;
  localparam int WMASK_WIDTH_DEF = DATA_WIDTH_DEF / 8;

  typedef logic [0:0]           port_idx_t;
  typedef logic [NUM_PORTS-1:0] grant_t;

  // Index of a one-hot grant; only meaningful when the grant is non-zero.
  function automatic port_idx_t grant_to_idx(input grant_t g);
    return port_idx_t'(g[1]);
  endfunction

  // Round-robin pick: a lone eligible port wins, a tie goes to the pointer.
  function automatic grant_t rr_pick(input grant_t elig, input port_idx_t ptr);
    grant_t g;
    if (elig == grant_t'(2'b11)) begin
      g = (ptr == port_idx_t'(1'b1)) ? grant_t'(2'b10) : grant_t'(2'b01);
    end else begin
      g = elig;
    end
    return g;
  endfunction

endpackage

// File: rtl/sram_arb_rsp_slot.sv
// Per-port read tracker: one in-flight flag plus a one-entry response buffer
// that captures the macro output the cycle after a read grant.
module sram_arb_rsp_slot
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_grant,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  free,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);

  logic rd_pend;
  logic pop;

  assign pop  = rsp_valid & rsp_ready;
  // A new read may start only if its data will land in an empty buffer.
  assign free = ~rd_pend & (~rsp_valid | rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // rd_pend lives exactly one cycle: set by the grant, cleared by the capture.
      rd_pend <= rd_grant;
      if (rd_pend) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= sram_dout;
      end else if (pop) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    rd_pend |-> (!rsp_valid || rsp_ready));

  a_grant_when_free: assert property (@(posedge clk) disable iff (!rst_n)
    rd_grant |-> free);

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester front end for a single-port SRAM macro: round-robin request
// arbitration, combinational macro drive and per-port buffered read responses.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int WMASK_WIDTH = WMASK_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*WMASK_WIDTH-1:0] req_wmask,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  input  logic [NUM_PORTS-1:0]             rsp_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rdata,
  output logic                             sram_we,
  output logic [WMASK_WIDTH-1:0]           sram_wmask,
  output logic [ADDR_WIDTH-1:0]            sram_addr,
  output logic [DATA_WIDTH-1:0]            sram_din,
  input  logic [DATA_WIDTH-1:0]            sram_dout
);

  logic [WMASK_WIDTH-1:0] wmask_a [NUM_PORTS];
  logic [ADDR_WIDTH-1:0]  addr_a  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  wdata_a [NUM_PORTS];

  grant_t    elig;
  grant_t    grant;
  grant_t    slot_free;
  port_idx_t gidx;
  port_idx_t rr_ptr;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign wmask_a[i] = req_wmask[i*WMASK_WIDTH +: WMASK_WIDTH];
    assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    // Writes never wait; reads wait for their response path to be free.
    assign elig[i]    = req_valid[i] & (req_we[i] | slot_free[i]);

    sram_arb_rsp_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_grant  (grant[i] & ~req_we[i]),
      .sram_dout (sram_dout),
      .free      (slot_free[i]),
      .rsp_valid (rsp_valid[i]),
      .rsp_ready (rsp_ready[i]),
      .rsp_rdata (rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Grant is held off while reset is asserted so req_ready reads 0.
  always_comb begin
    grant = '0;
    if (rst_n) begin
      grant = rr_pick(elig, rr_ptr);
    end
  end

  assign req_ready = grant;
  assign gidx      = grant_to_idx(grant);

  always_comb begin
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (|grant) begin
      sram_we    = req_we[gidx];
      sram_wmask = req_we[gidx] ? wmask_a[gidx] : '0;
      sram_addr  = addr_a[gidx];
      sram_din   = wdata_a[gidx];
    end
  end

  // After any grant the pointer favours the port that was not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= ~gidx;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));

  a_grant_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (grant & ~req_valid) == '0);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised and directed bench for sram_port_arbiter with a behavioural SRAM
// macro, a transaction-level reference model and per-port expected queues.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int MW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT hookup ----------------
  logic [1:0]      req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [2*MW-1:0] req_wmask;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata, rsp_rdata;
  logic            sram_we;
  logic [MW-1:0]   sram_wmask;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_din, sram_dout;

  logic          d_valid [2];
  logic          d_we    [2];
  logic [MW-1:0] d_mask  [2];
  logic [AW-1:0] d_addr  [2];
  logic [DW-1:0] d_data  [2];
  logic          d_rdy   [2];
  int            rdy_mode [2];

  assign req_valid = {d_valid[1], d_valid[0]};
  assign req_we    = {d_we[1], d_we[0]};
  assign req_wmask = {d_mask[1], d_mask[0]};
  assign req_addr  = {d_addr[1], d_addr[0]};
  assign req_wdata = {d_data[1], d_data[0]};
  assign rsp_ready = {d_rdy[1], d_rdy[0]};

  sram_port_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WMASK_WIDTH(MW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // Behavioural macro: synchronous read, byte-masked synchronous write.
  logic [DW-1:0] sram_mem [4096];
  always @(posedge clk) begin
    sram_dout <= sram_mem[sram_addr];
    if (sram_we)
      for (int b = 0; b < MW; b++)
        if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
  end

  // rsp_ready generator: 0 = hold off, 1 = always ready, 2 = random.
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < 2; p++)
      d_rdy[p] = (rdy_mode[p] == 0) ? 1'b0 :
                 (rdy_mode[p] == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [DW-1:0] ref_mem [4096];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  logic          pend      [2];
  int            rd_cyc    [2];
  logic          hold      [2];
  logic [DW-1:0] hold_data [2];
  logic [DW-1:0] last_pop  [2];
  logic          ptr;

  // Monitor: model of the observable protocol, evaluated mid-cycle.
  always @(negedge clk) begin
    logic          full [2];
    logic          pop  [2];
    logic [1:0]    elig;
    logic [1:0]    eg;
    int            gp;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] act_d;
    if (!rst_n) begin
      check("reset_req_ready", 64'(req_ready), 64'(0));
      check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      check("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
      check("reset_sram_we", 64'(sram_we), 64'(0));
      check("reset_sram_bus", {32'(sram_wmask), 20'd0, sram_addr}, 64'(0));
      check("reset_sram_din", 64'(sram_din), 64'(0));
      exp_q0.delete();
      exp_q1.delete();
      for (int p = 0; p < 2; p++) begin
        pend[p] = 1'b0;
        hold[p] = 1'b0;
      end
      ptr = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        full[p] = pend[p] && (cyc >= rd_cyc[p] + 2);
        pop[p]  = full[p] && d_rdy[p];
        check($sformatf("rsp_valid%0d", p), 64'(rsp_valid[p]), 64'(full[p]));
        if (hold[p])
          check($sformatf("rsp_hold%0d", p), 64'(rsp_rdata[p*DW +: DW]), 64'(hold_data[p]));
        elig[p] = d_valid[p] && (d_we[p] || !pend[p] || pop[p]);
      end
      if (elig == 2'b11) eg = ptr ? 2'b10 : 2'b01;
      else               eg = elig;
      check("req_ready", 64'(req_ready), 64'(eg));
      gp = eg[1] ? 1 : 0;
      if (eg != 2'b00) begin
        check("sram_we", 64'(sram_we), 64'(d_we[gp]));
        check("sram_addr", 64'(sram_addr), 64'(d_addr[gp]));
        check("sram_wmask", 64'(sram_wmask), d_we[gp] ? 64'(d_mask[gp]) : 64'(0));
        check("sram_din", 64'(sram_din), 64'(d_data[gp]));
      end else begin
        check("idle_sram_we", 64'(sram_we), 64'(0));
        check("idle_sram_bus", {32'(sram_wmask), 20'd0, sram_addr}, 64'(0));
      end
      for (int p = 0; p < 2; p++) begin
        act_d = rsp_rdata[p*DW +: DW];
        if (pop[p]) begin
          if (p == 0) exp_d = (exp_q0.size() > 0) ? exp_q0.pop_front() : 'x;
          else        exp_d = (exp_q1.size() > 0) ? exp_q1.pop_front() : 'x;
          check($sformatf("rsp_data%0d", p), 64'(act_d), 64'(exp_d));
          last_pop[p] = act_d;
          pend[p] = 1'b0;
        end
        hold[p]      = full[p] && !d_rdy[p];
        hold_data[p] = act_d;
      end
      if (eg != 2'b00) begin
        if (d_we[gp]) begin
          for (int b = 0; b < MW; b++)
            if (d_mask[gp][b]) ref_mem[d_addr[gp]][8*b +: 8] = d_data[gp][8*b +: 8];
        end else begin
          if (gp == 0) exp_q0.push_back(ref_mem[d_addr[gp]]);
          else         exp_q1.push_back(ref_mem[d_addr[gp]]);
          pend[gp]   = 1'b1;
          rd_cyc[gp] = cyc;
        end
        ptr = (gp == 0);
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left just after a rising edge; holds the request until accepted.
  task automatic do_req(input int p, input logic we, input logic [MW-1:0] m,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    int waited = 0;
    d_valid[p] = 1'b1;
    d_we[p]    = we;
    d_mask[p]  = m;
    d_addr[p]  = a;
    d_data[p]  = d;
    forever begin
      @(negedge clk);
      if (req_ready[p]) break;
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("FAIL req_timeout port%0d actual=no_ready required=ready", p);
        break;
      end
    end
    @(posedge clk);
    #1;
    d_valid[p] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] v;
    for (int p = 0; p < 2; p++) begin
      d_valid[p] = 1'b0; d_we[p] = 1'b0; d_mask[p] = '0;
      d_addr[p] = '0; d_data[p] = '0; d_rdy[p] = 1'b1;
      rdy_mode[p] = 1; pend[p] = 1'b0; hold[p] = 1'b0; last_pop[p] = '0;
    end
    ptr = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end

    idle(3);
    rst_n = 1'b1;
    idle(6);

    // full write then read-back
    do_req(0, 1'b1, 4'hF, 12'h005, 32'hDEADBEEF);
    do_req(0, 1'b0, 4'h0, 12'h005, 32'h0);
    idle(4);
    check("rd_005", 64'(last_pop[0]), 64'(32'hDEADBEEF));

    // partial byte-mask write
    do_req(0, 1'b1, 4'hF, 12'h010, 32'h11223344);
    do_req(0, 1'b1, 4'h5, 12'h010, 32'hAABBCCDD);
    do_req(0, 1'b0, 4'h0, 12'h010, 32'h0);
    idle(4);
    check("rd_010_masked", 64'(last_pop[0]), 64'(32'h11BB33DD));

    // both ports streaming reads
    do_req(0, 1'b1, 4'hF, 12'h001, 32'h0000000A);
    do_req(1, 1'b1, 4'hF, 12'h002, 32'h0000000B);
    fork
      repeat (8) do_req(0, 1'b0, 4'h0, 12'h001, 32'h0);
      repeat (8) do_req(1, 1'b0, 4'h0, 12'h002, 32'h0);
    join
    idle(4);
    check("stream_p0", 64'(last_pop[0]), 64'(32'h0000000A));
    check("stream_p1", 64'(last_pop[1]), 64'(32'h0000000B));

    // backpressure on port 1
    do_req(1, 1'b1, 4'hF, 12'hFFF, 32'hCAFEF00D);
    rdy_mode[1] = 0;
    idle(1);
    do_req(1, 1'b0, 4'h0, 12'hFFF, 32'h0);
    idle(5);
    fork
      do_req(1, 1'b0, 4'h0, 12'hFFF, 32'h0);
      begin
        do_req(0, 1'b1, 4'h3, 12'h020, $urandom);
        do_req(0, 1'b1, 4'hF, 12'h021, $urandom);
        rdy_mode[1] = 1;
      end
    join
    idle(4);
    check("bp_p1", 64'(last_pop[1]), 64'(32'hCAFEF00D));

    // reset while a read is in flight
    do_req(0, 1'b0, 4'h0, 12'h005, 32'h0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(4);
    do_req(0, 1'b0, 4'h0, 12'h010, 32'h0);
    idle(4);
    check("post_reset_rd", 64'(last_pop[0]), 64'(32'h11BB33DD));

    // random mixed traffic with random backpressure
    rdy_mode[0] = 2;
    rdy_mode[1] = 2;
    fork
      for (int k = 0; k < 60; k++) begin
        idle($urandom_range(0, 2));
        do_req(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               12'($urandom_range(0, 15)), $urandom);
      end
      for (int k = 0; k < 60; k++) begin
        idle($urandom_range(0, 2));
        do_req(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               12'($urandom_range(0, 15)), $urandom);
      end
    join
    rdy_mode[0] = 1;
    rdy_mode[1] = 1;
    idle(8);
    check("drain_q0", 64'(exp_q0.size()), 64'(0));
    check("drain_q1", 64'(exp_q1.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
